bank_sequencer: RTL and testbench

BANK_SEQUENCER -- requirements
Module: bank_sequencer

---
 rtl/bank_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_bank_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bank_sequencer.sv
// Sequences the modulator through data banks: optional preamble, one or more
// passes over a snapshotted bank list, optional idle gap between passes.
module bank_sequencer (
    input  logic        MAIN_CLK_i,
    input  logic        MAIN_RST_i,
    input  logic        START_i,
    input  logic        ABORT_i,
    input  logic        STEP_DONE_i,
    input  logic [35:0] CFREG_DATA_BANK_SEQUENCE_i,
    input  logic        CFREG_DATA_SEL_SINGLE_SEQUENCE_i,
    input  logic [3:0]  CFREG_DATA_BANK_SELECT_i,
    input  logic [3:0]  CFREG_DATA_BANK_REPEAT_i,
    input  logic [4:0]  CFREG_DELAY_DATA_BANK_REPEAT_i,
    input  logic        CFREG_PREAMB_i,
    input  logic        CFREG_REPEAT_WITH_PREAMB_i,
    output logic [8:0]  DATA_REG_MUX_SEL_DATA_o,
    output logic        DATA_REG_MUX_EN_o,
    output logic        PREAMB_REQ_o,
    output logic        BUSY_o,
    output logic        DONE_o,
    output logic        ERR_o,
    output logic [3:0]  STEP_IDX_o,
    output logic [3:0]  PASS_CNT_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMB,
        S_XFER,
        S_GAP,
        S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [35:0] seq_q, seq_d;
    logic        single_q, single_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  rep_q, rep_d;
    logic [4:0]  dly_q, dly_d;
    logic        pre_q, pre_d;
    logic        rwp_q, rwp_d;
    logic [3:0]  step_q, step_d;
    logic [3:0]  pass_q, pass_d;
    logic [4:0]  gap_q, gap_d;
    logic        err_q, err_d;

    logic [3:0]  cur_code;
    logic [3:0]  nxt_code;
    logic [3:0]  first_code_in;
    state_t      entry_state;

    function automatic logic [3:0] code_at(input logic [35:0] seq, input logic [3:0] idx);
        logic [35:0] sh;
        sh = seq << {idx, 2'b00};
        return sh[35:32];
    endfunction

    assign cur_code      = single_q ? sel_q : code_at(seq_q, step_q);
    assign nxt_code      = code_at(seq_q, step_q + 4'd1);
    assign first_code_in = CFREG_DATA_SEL_SINGLE_SEQUENCE_i ? CFREG_DATA_BANK_SELECT_i
                                                            : CFREG_DATA_BANK_SEQUENCE_i[35:32];
    assign entry_state   = (pre_q && rwp_q) ? S_PREAMB : S_XFER;

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        single_d = single_q;
        sel_d    = sel_q;
        rep_d    = rep_q;
        dly_d    = dly_q;
        pre_d    = pre_q;
        rwp_d    = rwp_q;
        step_d   = step_q;
        pass_d   = pass_q;
        gap_d    = gap_q;
        err_d    = 1'b0;

        // Abort wins over any concurrent STEP_DONE; counters keep their values.
        if (ABORT_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (START_i) begin
                        if (first_code_in > 4'd8) begin
                            err_d = 1'b1;
                        end else begin
                            seq_d    = CFREG_DATA_BANK_SEQUENCE_i;
                            single_d = CFREG_DATA_SEL_SINGLE_SEQUENCE_i;
                            sel_d    = CFREG_DATA_BANK_SELECT_i;
                            rep_d    = CFREG_DATA_BANK_REPEAT_i;
                            dly_d    = CFREG_DELAY_DATA_BANK_REPEAT_i;
                            pre_d    = CFREG_PREAMB_i;
                            rwp_d    = CFREG_REPEAT_WITH_PREAMB_i;
                            step_d   = 4'd0;
                            pass_d   = 4'd0;
                            state_d  = CFREG_PREAMB_i ? S_PREAMB : S_XFER;
                        end
                    end
                end
                S_PREAMB: begin
                    if (STEP_DONE_i) begin
                        state_d = S_XFER;
                        step_d  = 4'd0;
                    end
                end
                S_XFER: begin
                    if (STEP_DONE_i) begin
                        if (!single_q && (step_q < 4'd8) && (nxt_code <= 4'd8)) begin
                            step_d = step_q + 4'd1;
                        end else if (pass_q == rep_q) begin
                            state_d = S_FINISH;
                        end else begin
                            pass_d = pass_q + 4'd1;
                            step_d = 4'd0;
                            if (dly_q != 5'd0) begin
                                state_d = S_GAP;
                                gap_d   = dly_q;
                            end else begin
                                state_d = entry_state;
                            end
                        end
                    end
                end
                S_GAP: begin
                    // gap_q holds the idle cycles still to spend, this one included.
                    if (gap_q <= 5'd1) begin
                        state_d = entry_state;
                    end else begin
                        gap_d = gap_q - 5'd1;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge MAIN_CLK_i or posedge MAIN_RST_i) begin
        if (MAIN_RST_i) begin
            state_q  <= S_IDLE;
            seq_q    <= 36'd0;
            single_q <= 1'b0;
            sel_q    <= 4'd0;
            rep_q    <= 4'd0;
            dly_q    <= 5'd0;
            pre_q    <= 1'b0;
            rwp_q    <= 1'b0;
            step_q   <= 4'd0;
            pass_q   <= 4'd0;
            gap_q    <= 5'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            single_q <= single_d;
            sel_q    <= sel_d;
            rep_q    <= rep_d;
            dly_q    <= dly_d;
            pre_q    <= pre_d;
            rwp_q    <= rwp_d;
            step_q   <= step_d;
            pass_q   <= pass_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
        end
    end

    assign BUSY_o                  = (state_q != S_IDLE);
    assign PREAMB_REQ_o            = (state_q == S_PREAMB);
    assign DATA_REG_MUX_EN_o       = (state_q == S_XFER);
    assign DATA_REG_MUX_SEL_DATA_o = (state_q == S_XFER) ? (9'd1 << cur_code) : 9'd0;
    assign DONE_o                  = (state_q == S_FINISH);
    assign ERR_o                   = err_q;
    assign STEP_IDX_o              = step_q;
    assign PASS_CNT_o              = pass_q;

endmodule

// File: tb/tb_bank_sequencer.sv
// Randomised and directed checks of bank_sequencer against a phase-list model.
module tb_bank_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort_s, step_done;
  logic [35:0] seq_in;
  logic        single_in, pre_in, rwp_in;
  logic [3:0]  sel_in, rep_in;
  logic [4:0]  dly_in;
  logic [8:0]  mux_sel;
  logic        mux_en, preamb_req, busy, done, err;
  logic [3:0]  step_idx, pass_cnt;

  bank_sequencer dut (
    .MAIN_CLK_i                       (clk),
    .MAIN_RST_i                       (rst),
    .START_i                          (start),
    .ABORT_i                          (abort_s),
    .STEP_DONE_i                      (step_done),
    .CFREG_DATA_BANK_SEQUENCE_i       (seq_in),
    .CFREG_DATA_SEL_SINGLE_SEQUENCE_i (single_in),
    .CFREG_DATA_BANK_SELECT_i         (sel_in),
    .CFREG_DATA_BANK_REPEAT_i         (rep_in),
    .CFREG_DELAY_DATA_BANK_REPEAT_i   (dly_in),
    .CFREG_PREAMB_i                   (pre_in),
    .CFREG_REPEAT_WITH_PREAMB_i       (rwp_in),
    .DATA_REG_MUX_SEL_DATA_o          (mux_sel),
    .DATA_REG_MUX_EN_o                (mux_en),
    .PREAMB_REQ_o                     (preamb_req),
    .BUSY_o                           (busy),
    .DONE_o                           (done),
    .ERR_o                            (err),
    .STEP_IDX_o                       (step_idx),
    .PASS_CNT_o                       (pass_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [21:0] M_ALL  = 22'h3FFFFF;
  localparam logic [21:0] M_NOSP = 22'h3FFFFF & ~22'h0003FC;

  typedef struct {int kind; int bank; int step; int pass;} ph_t;   // kind 0 preamble, 1 transfer, 2 gap
  ph_t plan[$];
  int  last_step;

  int checks = 0, errors = 0;
  int hold_step = 0, hold_pass = 0;
  bit hold_known = 1'b1;

  logic [35:0] c_seq;
  logic        c_single, c_pre, c_rwp;
  logic [3:0]  c_sel, c_rep;
  logic [4:0]  c_dly;

  function automatic logic [21:0] mk(input logic b, input logic p, input logic e, input logic [8:0] s,
                                     input int st, input int ps, input logic d, input logic r);
    return {b, p, e, s, 4'(st), 4'(ps), d, r};
  endfunction

  function automatic logic [21:0] exp_of(input ph_t ph);
    if (ph.kind == 0) return mk(1, 1, 0, 9'd0, ph.step, ph.pass, 0, 0);
    if (ph.kind == 1) return mk(1, 0, 1, 9'(1 << ph.bank), ph.step, ph.pass, 0, 0);
    return mk(1, 0, 0, 9'd0, 0, ph.pass, 0, 0);
  endfunction

  function automatic logic [21:0] idle_exp(input logic e);
    return mk(0, 0, 0, 9'd0, hold_step, hold_pass, 0, e);
  endfunction

  task automatic chk(input string tag, input logic [21:0] expv, input logic [21:0] mask);
    logic [21:0] o;
    o = {busy, preamb_req, mux_en, mux_sel, step_idx, pass_cnt, done, err};
    checks++;
    assert ((o & mask) === (expv & mask))
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o & mask, expv & mask);
    end
  endtask

  task automatic scramble();
    seq_in    = {4'($urandom), 32'($urandom)};
    single_in = 1'($urandom);
    sel_in    = 4'($urandom);
    rep_in    = 4'($urandom);
    dly_in    = 5'($urandom);
    pre_in    = 1'($urandom);
    rwp_in    = 1'($urandom);
  endtask

  task automatic build_plan();
    int banks[$];
    int c;
    plan.delete();
    if (c_single) banks.push_back(int'(c_sel));
    else begin
      for (int i = 0; i < 9; i++) begin
        c = int'((c_seq >> (4 * (8 - i))) & 36'hF);
        if (c > 8) break;
        banks.push_back(c);
      end
    end
    for (int p = 0; p <= int'(c_rep); p++) begin
      if (c_pre && (p == 0 || c_rwp)) plan.push_back('{0, 0, 0, p});
      for (int i = 0; i < banks.size(); i++) plan.push_back('{1, banks[i], i, p});
      if (p < int'(c_rep))
        for (int g = 0; g < int'(c_dly); g++) plan.push_back('{2, 0, 0, p + 1});
    end
    last_step = banks.size() - 1;
  endtask

  task automatic drive_cfg();
    seq_in = c_seq; single_in = c_single; sel_in = c_sel; rep_in = c_rep;
    dly_in = c_dly; pre_in = c_pre; rwp_in = c_rwp;
  endtask

  // abort_at / rst_at: phase index at which to abort or reset (-1 = never)
  task automatic run(input string name, input int abort_at, input int rst_at);
    int w;
    build_plan();
    @(negedge clk);
    drive_cfg();
    start = 1'b1; step_done = 1'b0; abort_s = 1'b0;
    for (int k = 0; k < plan.size(); k++) begin
      w = (plan[k].kind == 2) ? 0 : $urandom_range(0, 2);
      for (int j = 0; j <= w; j++) begin
        @(negedge clk);
        chk({name, " phase"}, exp_of(plan[k]), M_ALL);
        start = 1'($urandom);
        scramble();
        if (plan[k].kind == 2) begin
          step_done = 1'($urandom);
          if (k == rst_at) begin
            start = 1'b0; step_done = 1'b0;
            #2 rst = 1'b1;
            #1 chk({name, " async_rst"}, 22'd0, M_ALL);
            @(negedge clk);
            chk({name, " in_rst"}, 22'd0, M_ALL);
            rst = 1'b0;
            hold_step = 0; hold_pass = 0; hold_known = 1'b1;
            return;
          end
        end else begin
          step_done = (j == w);
        end
        if (k == abort_at && j == w) begin
          abort_s = 1'b1; step_done = 1'b1; start = 1'b0;
          @(negedge clk);
          abort_s = 1'b0; step_done = 1'b0;
          hold_known = 1'b0;
          chk({name, " abort"}, idle_exp(0), M_NOSP);
          @(negedge clk);
          chk({name, " abort_nodone"}, idle_exp(0), M_NOSP);
          return;
        end
      end
    end
    @(negedge clk);
    chk({name, " finish"}, mk(1, 0, 0, 9'd0, last_step, c_rep, 1, 0), M_ALL);
    start = 1'b0;
    step_done = 1'($urandom);
    hold_step = last_step; hold_pass = int'(c_rep); hold_known = 1'b1;
    @(negedge clk);
    chk({name, " idle_hold"}, idle_exp(0), M_ALL);
    step_done = 1'b0;
  endtask

  task automatic run_err(input string name);
    @(negedge clk);
    drive_cfg();
    start = 1'b1; step_done = 1'b0; abort_s = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({name, " err_pulse"}, idle_exp(1), hold_known ? M_ALL : M_NOSP);
    @(negedge clk);
    chk({name, " err_clear"}, idle_exp(0), hold_known ? M_ALL : M_NOSP);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort_s = 1'b0; step_done = 1'b0;
    scramble();
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset", 22'd0, M_ALL);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_release", 22'd0, M_ALL);

    c_seq = 36'h01234578F; c_single = 0; c_sel = 0; c_rep = 0; c_dly = 0; c_pre = 0; c_rwp = 0;
    run("seq8", -1, -1);

    c_single = 1; c_sel = 3; c_rep = 2; c_dly = 1; c_pre = 1; c_rwp = 1;
    run("single_pre", -1, -1);

    c_seq = 36'hF00000000; c_single = 0;
    run_err("bad_seq");
    c_single = 1; c_sel = 9;
    run_err("bad_sel");

    c_seq = 36'h01234578F; c_single = 0; c_rep = 1; c_dly = 0; c_pre = 0; c_rwp = 0;
    run("abort", 2, -1);

    c_single = 1; c_sel = 5; c_rep = 1; c_dly = 3; c_pre = 0;
    run("rst_gap", -1, 2);
    c_rep = 0;
    run("after_rst", -1, -1);

    c_seq = 36'h876543210; c_single = 0; c_rep = 1; c_dly = 2; c_pre = 1; c_rwp = 0;
    run("nine_steps", -1, -1);

    for (int r = 0; r < 30; r++) begin
      c_single = 1'($urandom);
      c_sel    = 4'($urandom_range(0, 8));
      c_seq    = 36'd0;
      for (int i = 0; i < 9; i++) c_seq = (c_seq << 4) | 36'($urandom_range(0, 10));
      c_seq[35:32] = 4'($urandom_range(0, 8));
      c_rep    = 4'($urandom_range(0, 3));
      c_dly    = 5'($urandom_range(0, 3));
      c_pre    = 1'($urandom);
      c_rwp    = 1'($urandom);
      run("rand", -1, -1);
      if (r % 6 == 5) begin
        if (c_single) c_sel = 4'($urandom_range(9, 15));
        else c_seq[35:32] = 4'($urandom_range(9, 15));
        run_err("rand_err");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
